// File: rtl/osc_filter_cfg_seq.sv
// osc_filter_cfg_seq: applies register-bank coefficients to the IIR filter glitch-free
// (force bypass, swap coefficients, release) and tracks flush/settle status.
module osc_filter_cfg_seq #(
   parameter int SETTLE_CYC = 4,
   parameter int FW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [17:0]   reg_aa_i,
   input  logic [24:0]   reg_bb_i,
   input  logic [24:0]   reg_kk_i,
   input  logic [24:0]   reg_pp_i,
   input  logic          reg_bypass_i,
   input  logic          commit_i,
   input  logic [FW-1:0] flush_len_i,
   input  logic          sample_valid_i,
   output logic          cfg_bypass,
   output logic [17:0]   cfg_coeff_aa,
   output logic [24:0]   cfg_coeff_bb,
   output logic [24:0]   cfg_coeff_kk,
   output logic [24:0]   cfg_coeff_pp,
   output logic          busy_o,
   output logic          settled_o,
   output logic          pending_o
);
   typedef enum logic [2:0] {IDLE, ENTER_BYP, LOAD, RELEASE, FLUSH} state_t;
   state_t        state;
   logic [17:0]   stg_aa;
   logic [24:0]   stg_bb;
   logic [24:0]   stg_kk;
   logic [24:0]   stg_pp;
   logic [3:0]    settle_cnt;
   logic [FW-1:0] flush_cnt;
   logic [FW-1:0] flush_len;
   logic          start;
   // a queued commit restarts the sequence exactly like a fresh one
   assign start = commit_i | pending_o;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         stg_aa       <= '0;
         stg_bb       <= '0;
         stg_kk       <= '0;
         stg_pp       <= '0;
         settle_cnt   <= '0;
         flush_cnt    <= '0;
         flush_len    <= '0;
         cfg_bypass   <= 1'b1;
         cfg_coeff_aa <= '0;
         cfg_coeff_bb <= '0;
         cfg_coeff_kk <= '0;
         cfg_coeff_pp <= '0;
         busy_o       <= 1'b0;
         settled_o    <= 1'b1;
         pending_o    <= 1'b0;
      end else begin
         if (state != IDLE && commit_i) pending_o <= 1'b1;
         case (state)
            IDLE: begin
               if (start) begin
                  stg_aa     <= reg_aa_i;
                  stg_bb     <= reg_bb_i;
                  stg_kk     <= reg_kk_i;
                  stg_pp     <= reg_pp_i;
                  pending_o  <= 1'b0;
                  cfg_bypass <= 1'b1;
                  busy_o     <= 1'b1;
                  settled_o  <= 1'b0;
                  settle_cnt <= '0;
                  state      <= ENTER_BYP;
               end else begin
                  cfg_bypass <= reg_bypass_i;
                  if (cfg_bypass && !reg_bypass_i) begin
                     flush_len <= flush_len_i;
                     flush_cnt <= '0;
                     busy_o    <= 1'b1;
                     settled_o <= 1'b0;
                     state     <= FLUSH;
                  end else if (!cfg_bypass && reg_bypass_i) begin
                     settled_o <= 1'b1;
                  end
               end
            end
            ENTER_BYP: begin
               if (settle_cnt == 4'(SETTLE_CYC - 1)) state <= LOAD;
               else settle_cnt <= settle_cnt + 4'd1;
            end
            LOAD: begin
               cfg_coeff_aa <= stg_aa;
               cfg_coeff_bb <= stg_bb;
               cfg_coeff_kk <= stg_kk;
               cfg_coeff_pp <= stg_pp;
               state        <= RELEASE;
            end
            RELEASE: begin
               cfg_bypass <= reg_bypass_i;
               if (reg_bypass_i) begin
                  busy_o    <= 1'b0;
                  settled_o <= 1'b1;
                  state     <= IDLE;
               end else begin
                  flush_len <= flush_len_i;
                  flush_cnt <= '0;
                  state     <= FLUSH;
               end
            end
            FLUSH: begin
               // equality compare: a zero length exits after exactly one cycle
               if (flush_cnt == flush_len) begin
                  busy_o    <= 1'b0;
                  settled_o <= 1'b1;
                  state     <= IDLE;
               end else begin
                  flush_cnt <= flush_cnt + FW'(sample_valid_i);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_osc_filter_cfg_seq.sv
// tb_osc_filter_cfg_seq: vector table, directed corner sequences and randomized run
// checked against a timeline-based reference model.
module tb_osc_filter_cfg_seq;
   localparam int SETTLE_CYC = 4;
   localparam int FW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [17:0]   reg_aa;
   logic [24:0]   reg_bb, reg_kk, reg_pp;
   logic          reg_bypass, commit, sample_valid;
   logic [FW-1:0] flush_len;
   logic          cfg_bypass, busy_o, settled_o, pending_o;
   logic [17:0]   cfg_coeff_aa;
   logic [24:0]   cfg_coeff_bb, cfg_coeff_kk, cfg_coeff_pp;

   int checks = 0;
   int errors = 0;

   osc_filter_cfg_seq #(.SETTLE_CYC(SETTLE_CYC), .FW(FW)) dut (
      .clk(clk), .rst_n(rst_n),
      .reg_aa_i(reg_aa), .reg_bb_i(reg_bb), .reg_kk_i(reg_kk), .reg_pp_i(reg_pp),
      .reg_bypass_i(reg_bypass), .commit_i(commit), .flush_len_i(flush_len),
      .sample_valid_i(sample_valid),
      .cfg_bypass(cfg_bypass), .cfg_coeff_aa(cfg_coeff_aa), .cfg_coeff_bb(cfg_coeff_bb),
      .cfg_coeff_kk(cfg_coeff_kk), .cfg_coeff_pp(cfg_coeff_pp),
      .busy_o(busy_o), .settled_o(settled_o), .pending_o(pending_o)
   );

   always #5 clk = ~clk;

   // reference model: sequence age in edges since commit, remaining flush samples
   logic        m_byp, m_busy, m_settled, m_pend;
   logic [17:0] m_aa, s_aa;
   logic [24:0] m_bb, m_kk, m_pp, s_bb, s_kk, s_pp;
   bit          m_in_seq, m_flushing;
   int          m_age, m_need;

   task automatic m_reset();
      m_byp = 1'b1; m_busy = 1'b0; m_settled = 1'b1; m_pend = 1'b0;
      m_aa = '0; m_bb = '0; m_kk = '0; m_pp = '0;
      s_aa = '0; s_bb = '0; s_kk = '0; s_pp = '0;
      m_in_seq = 0; m_flushing = 0; m_age = 0; m_need = 0;
   endtask

   task automatic model_edge();
      bit was_busy;
      was_busy = m_in_seq || m_flushing;
      if (!rst_n) begin
         m_reset();
         return;
      end
      if (m_flushing) begin
         if (m_need == 0) begin
            m_flushing = 0; m_settled = 1'b1; m_busy = 1'b0;
         end else m_need = m_need - int'(sample_valid);
      end else if (m_in_seq) begin
         m_age++;
         if (m_age == SETTLE_CYC + 1) begin
            m_aa = s_aa; m_bb = s_bb; m_kk = s_kk; m_pp = s_pp;
         end
         if (m_age == SETTLE_CYC + 2) begin
            m_in_seq = 0;
            m_byp = reg_bypass;
            if (reg_bypass) begin
               m_settled = 1'b1; m_busy = 1'b0;
            end else begin
               m_flushing = 1; m_need = int'(flush_len);
            end
         end
      end else if (commit || m_pend) begin
         s_aa = reg_aa; s_bb = reg_bb; s_kk = reg_kk; s_pp = reg_pp;
         m_pend = 1'b0; m_byp = 1'b1; m_busy = 1'b1; m_settled = 1'b0;
         m_in_seq = 1; m_age = 0;
      end else if (m_byp && !reg_bypass) begin
         m_byp = 1'b0; m_busy = 1'b1; m_settled = 1'b0;
         m_flushing = 1; m_need = int'(flush_len);
      end else begin
         if (!m_byp && reg_bypass) m_settled = 1'b1;
         m_byp = reg_bypass;
      end
      if (was_busy && commit) m_pend = 1'b1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      check("mdl_byp", 32'(cfg_bypass), 32'(m_byp));
      check("mdl_busy", 32'(busy_o), 32'(m_busy));
      check("mdl_settled", 32'(settled_o), 32'(m_settled));
      check("mdl_pend", 32'(pending_o), 32'(m_pend));
      check("mdl_aa", 32'(cfg_coeff_aa), 32'(m_aa));
      check("mdl_bb", 32'(cfg_coeff_bb), 32'(m_bb));
      check("mdl_kk", 32'(cfg_coeff_kk), 32'(m_kk));
      check("mdl_pp", 32'(cfg_coeff_pp), 32'(m_pp));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_model();
   endtask

   task automatic set_coeffs(input logic [17:0] a, input logic [24:0] b, input logic [24:0] k,
                             input logic [24:0] p);
      reg_aa = a; reg_bb = b; reg_kk = k; reg_pp = p;
   endtask

   // fields: commit, reg_bypass, valid | expected cfg_bypass, busy, settled, new coeffs
   typedef struct packed {
      logic commit, byp_in, valid, e_byp, e_busy, e_settled, e_new;
   } vec_t;
   vec_t tbl [17];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap, lat;
      bit done, dropped;
      tbl = '{7'b1011100, 7'b0011100, 7'b0011100, 7'b0011100, 7'b0011100,
              7'b0011101, 7'b0010101, 7'b0010101, 7'b0010101, 7'b0010101,
              7'b0010101, 7'b0010101, 7'b0010101, 7'b0010101, 7'b0010101,
              7'b0010011, 7'b0010011};
      rst_n = 1'b0; commit = 1'b0; reg_bypass = 1'b1; sample_valid = 1'b0;
      flush_len = FW'(8);
      set_coeffs('0, '0, '0, '0);
      m_reset();
      @(negedge clk);
      @(negedge clk);
      check("rst_byp", 32'(cfg_bypass), 32'd1);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_settled", 32'(settled_o), 32'd1);
      check("rst_pend", 32'(pending_o), 32'd0);
      check("rst_aa", 32'(cfg_coeff_aa), 32'd0);
      rst_n = 1'b1;
      step();

      set_coeffs(18'h1F000, 25'h0A0000, 25'h7FFFFF, 25'h100000);
      for (int i = 0; i < 17; i++) begin
         commit = tbl[i].commit; reg_bypass = tbl[i].byp_in; sample_valid = tbl[i].valid;
         step();
         check("tbl_byp", 32'(cfg_bypass), 32'(tbl[i].e_byp));
         check("tbl_busy", 32'(busy_o), 32'(tbl[i].e_busy));
         check("tbl_settled", 32'(settled_o), 32'(tbl[i].e_settled));
         check("tbl_aa", 32'(cfg_coeff_aa), tbl[i].e_new ? 32'h1F000 : 32'h0);
         check("tbl_bb", 32'(cfg_coeff_bb), tbl[i].e_new ? 32'h0A0000 : 32'h0);
         check("tbl_kk", 32'(cfg_coeff_kk), tbl[i].e_new ? 32'h7FFFFF : 32'h0);
         check("tbl_pp", 32'(cfg_coeff_pp), tbl[i].e_new ? 32'h100000 : 32'h0);
      end
      commit = 1'b0;

      // second commit during FLUSH is queued and applied after the first settles
      set_coeffs(18'h00123, 25'h0000456, 25'h0000789, 25'h0000ABC);
      commit = 1'b1; step(); commit = 1'b0;
      for (int i = 0; i < 8; i++) step();
      set_coeffs(18'h2AAAA, 25'h0123456, 25'h1ABCDEF, 25'h0000001);
      commit = 1'b1; step(); commit = 1'b0;
      check("pend_set", 32'(pending_o), 32'd1);
      gap = 0; done = 0;
      for (int k = 0; k < 100 && !done; k++) begin
         step();
         if (!busy_o && pending_o) gap++;
         if (!busy_o && !pending_o) done = 1;
      end
      check("pend_done", 32'(done), 32'd1);
      check("pend_gap", 32'(gap), 32'd1);
      check("pend_aa", 32'(cfg_coeff_aa), 32'h2AAAA);
      check("pend_kk", 32'(cfg_coeff_kk), 32'h1ABCDEF);

      // IDLE bypass toggling with zero flush length
      flush_len = '0;
      reg_bypass = 1'b1; step();
      check("tog_rise_byp", 32'(cfg_bypass), 32'd1);
      check("tog_rise_settled", 32'(settled_o), 32'd1);
      reg_bypass = 1'b0; step();
      check("tog_fall_byp", 32'(cfg_bypass), 32'd0);
      check("tog_fall_settled", 32'(settled_o), 32'd0);
      step();
      check("tog_after_settled", 32'(settled_o), 32'd1);
      check("tog_after_busy", 32'(busy_o), 32'd0);

      // commit with bypass requested: no FLUSH, settled right after RELEASE
      flush_len = FW'(5);
      set_coeffs(18'h3FFFF, 25'h1FFFFFF, 25'h0F0F0F0, 25'h1234567);
      reg_bypass = 1'b1; commit = 1'b1; step(); commit = 1'b0;
      lat = 1; dropped = 0;
      while (!settled_o && lat < 20) begin
         step(); lat++;
         if (!cfg_bypass) dropped = 1;
      end
      check("byp_lat", 32'(lat), 32'(SETTLE_CYC + 3));
      check("byp_held", 32'(dropped), 32'd0);
      check("byp_aa", 32'(cfg_coeff_aa), 32'h3FFFF);
      step();
      check("byp_no_flush", 32'(busy_o), 32'd0);

      // asynchronous reset while in LOAD
      set_coeffs(18'h00001, 25'h0000002, 25'h0000003, 25'h0000004);
      commit = 1'b1; step(); commit = 1'b0;
      for (int i = 0; i < SETTLE_CYC; i++) step();
      #2 rst_n = 1'b0;
      #1;
      check("arst_aa", 32'(cfg_coeff_aa), 32'd0);
      check("arst_bb", 32'(cfg_coeff_bb), 32'd0);
      check("arst_byp", 32'(cfg_bypass), 32'd1);
      check("arst_busy", 32'(busy_o), 32'd0);
      check("arst_pend", 32'(pending_o), 32'd0);
      check("arst_settled", 32'(settled_o), 32'd1);
      m_reset();
      step();
      rst_n = 1'b1;
      step();

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         commit = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 3) == 0)
            set_coeffs(18'($urandom), 25'($urandom), 25'($urandom), 25'($urandom));
         if ($urandom_range(0, 24) == 0) reg_bypass = ~reg_bypass;
         sample_valid = 1'($urandom_range(0, 1));
         flush_len = FW'($urandom_range(0, 10));
         step();
      end
      commit = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/osc_filter_cfg_seq.md
Name: osc_filter_cfg_seq

Overview:
- Configuration sequencer for the oscilloscope IIR compensation filter.
- Takes coefficient and bypass settings written by the register bank and applies them to the filter without glitches. It forces the filter into bypass, swaps the coefficients, then releases bypass; the filter clears its own state on the bypass falling edge.
- Counts valid input samples until the filter has settled, and reports busy/settled status back to the register bank and the acquisition trigger logic.

Parameters:
- SETTLE_CYC, 4: clk cycles bypass is held before new coefficients are driven (range 1..15).
- FW, 16: width of the flush sample counter and of flush_len_i.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- reg_aa_i  in  18  requested coeff AA
- reg_bb_i  in  25  requested coeff BB
- reg_kk_i  in  25  requested coeff KK
- reg_pp_i  in  25  requested coeff PP
- reg_bypass_i  in  1  requested bypass level
- commit_i  in  1  single-cycle pulse: apply reg_* coefficients
- flush_len_i  in  FW  number of valid samples to discard after release
- sample_valid_i  in  1  filter input tvalid
- cfg_bypass  out  1  to filter
- cfg_coeff_aa  out  18  to filter
- cfg_coeff_bb  out  25  to filter
- cfg_coeff_kk  out  25  to filter
- cfg_coeff_pp  out  25  to filter
- busy_o  out  1  sequence in progress
- settled_o  out  1  filter output valid for acquisition
- pending_o  out  1  a commit is queued

Behaviour:
- Reset values (async on rst_n low): all cfg_coeff_* = 0; cfg_bypass = 1; busy_o = 0; settled_o = 1; pending_o = 0; state IDLE; all counters 0.
- All outputs are registered.
- Commit acceptance:
  - In IDLE, commit_i snapshots all reg_* coefficients into staging registers on that edge and moves to ENTER_BYP next cycle.
  - In any other state, commit_i sets pending_o; staging is not touched.
  - When the FSM returns to IDLE with pending_o = 1, it snapshots reg_* at that cycle, clears pending_o and starts again. Further commits while pending is set are merged into the single pending entry.
- FSM:
  - IDLE: busy_o = 0.
    - cfg_bypass <= reg_bypass_i every cycle.
    - Falling edge of reg_bypass_i (registered cfg_bypass 1 -> 0) -> FLUSH with settled_o = 0.
    - Rising edge -> settled_o = 1 immediately (raw data path).
  - ENTER_BYP: busy_o = 1, cfg_bypass = 1, settled_o = 0.
    - Counter runs 0..SETTLE_CYC-1, then -> LOAD.
  - LOAD: one cycle. cfg_coeff_* <= staging; cfg_bypass stays 1 -> RELEASE.
  - RELEASE: one cycle. cfg_bypass <= reg_bypass_i.
    - If that value is 1 -> IDLE with settled_o = 1.
    - Else -> FLUSH.
  - FLUSH: busy_o = 1, settled_o = 0.
    - flush_len_i is latched on entry.
    - Counter increments only on sample_valid_i.
    - When the count equals the latched length -> IDLE, settled_o = 1 the same edge.
    - flush_len_i = 0: FLUSH lasts exactly one cycle.
- Coefficient outputs change only in LOAD, and cfg_bypass is 1 whenever they change.
- Minimum latency from commit_i to cfg_coeff update: SETTLE_CYC+1 edges.
- Falling edge of reg_bypass_i during ENTER_BYP/LOAD: ignored until RELEASE samples it. During FLUSH it is also ignored: cfg_bypass is not re-driven until IDLE, and IDLE then resumes tracking.
- Counter wrap: the FW-bit counter compares for equality, so the maximum flush length is 2^FW-1 samples and there is no wrap.
- Reset asserted mid-sequence: immediate return to reset values; a half-applied set is impossible because coefficients are updated atomically in LOAD.

Test Plan:
- Reset, then commit_i with aa=0x1F000, bb=0x0A0000, kk=0x7FFFFF, pp=0x100000, bypass=0, flush_len=8, valid every cycle:
  - cfg_bypass = 1 for SETTLE_CYC+1 cycles; coefficients update on cycle 5 after commit.
  - cfg_bypass falls at cycle 6; settled_o rises after exactly 8 valid samples; busy_o is high throughout.
- Same sequence with sample_valid_i toggling 1/0: FLUSH takes 16 clk cycles; settled_o timing is tied to valid count only.
- Second commit issued during FLUSH with different coefficients:
  - pending_o = 1.
  - After first settle, the sequence restarts with no IDLE gap longer than 1 cycle.
  - Final cfg_coeff_* equal the second set.
- Commit with reg_bypass_i = 1: coefficients load, cfg_bypass stays 1, settled_o = 1 at RELEASE+1, no FLUSH.
- In IDLE, toggle reg_bypass_i 0 -> 1 -> 0 with flush_len = 0:
  - cfg_bypass follows with 1-cycle latency.
  - settled_o is low for exactly one cycle after the falling edge.
- Assert rst_n low during LOAD: outputs return asynchronously to reset values (coeffs 0, bypass 1, busy 0, pending 0) with no clock edge needed.
